// File: rtl/axis_pkt_arbiter.sv
// Round-robin AXI-Stream packet arbiter: S_COUNT sources onto one master port,
// grant held from first beat through TLAST, one idle cycle between packets.
module axis_pkt_arbiter #(
    parameter int unsigned S_COUNT      = 4,
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned T_ID_WIDTH   = 8,
    parameter int unsigned T_USER_WIDTH = 8,
    localparam int unsigned GW          = $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [S_COUNT*T_DATA_WIDTH-1:0]  s_data,
    input  logic [S_COUNT*T_ID_WIDTH-1:0]    s_id,
    input  logic [S_COUNT*T_USER_WIDTH-1:0]  s_user,
    input  logic [S_COUNT-1:0]               s_last,
    input  logic [S_COUNT-1:0]               s_valid,
    output logic [S_COUNT-1:0]               s_ready,
    output logic [T_DATA_WIDTH-1:0]          m_data,
    output logic [T_ID_WIDTH-1:0]            m_id,
    output logic [T_USER_WIDTH-1:0]          m_user,
    output logic                             m_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [GW-1:0]                    grant_idx,
    output logic                             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;

    logic            found;
    logic [GW-1:0]   pick;

    logic                    sel_valid;
    logic                    sel_last;
    logic [T_DATA_WIDTH-1:0] sel_data;
    logic [T_ID_WIDTH-1:0]   sel_id;
    logic [T_USER_WIDTH-1:0] sel_user;

    // Round-robin search: first pass covers rr..S_COUNT-1, second pass wraps to 0..rr-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned j = 0; j < S_COUNT; j++) begin
            if (!found && s_valid[j] && (GW'(j) >= rr_q)) begin
                found = 1'b1;
                pick  = GW'(j);
            end
        end
        for (int unsigned j = 0; j < S_COUNT; j++) begin
            if (!found && s_valid[j]) begin
                found = 1'b1;
                pick  = GW'(j);
            end
        end
    end

    // Payload mux for the granted source.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_id    = '0;
        sel_user  = '0;
        for (int unsigned j = 0; j < S_COUNT; j++) begin
            if (GW'(j) == grant_q) begin
                sel_valid = s_valid[j];
                sel_last  = s_last[j];
                sel_data  = s_data[j*T_DATA_WIDTH +: T_DATA_WIDTH];
                sel_id    = s_id[j*T_ID_WIDTH +: T_ID_WIDTH];
                sel_user  = s_user[j*T_USER_WIDTH +: T_USER_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state and datapath steering; the master side is a pure mux while BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        s_ready = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        m_id    = '0;
        m_user  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_valid = sel_valid;
                m_last  = sel_last;
                m_data  = sel_data;
                m_id    = sel_id;
                m_user  = sel_user;
                for (int unsigned j = 0; j < S_COUNT; j++) begin
                    s_ready[j] = (GW'(j) == grant_q) && m_ready;
                end
                if (sel_valid && m_ready && sel_last) begin
                    rr_d    = (grant_q == GW'(S_COUNT - 1)) ? '0 : grant_q + GW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: directed sequences, an arbitration vector table,
// and a randomized run scored against a packet-level round-robin model.
module tb_axis_pkt_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned M = 3;

    logic clk;
    logic reset_n;

    logic [N*8-1:0] s_data, s_id, s_user;
    logic [N-1:0]   s_last, s_valid, s_ready;
    logic [7:0]     m_data, m_id, m_user;
    logic           m_last, m_valid, m_ready, busy;
    logic [1:0]     grant_idx;

    logic [M*8-1:0] t_data, t_id, t_user;
    logic [M-1:0]   t_last, t_valid, t_ready;
    logic [7:0]     t_mdata, t_mid, t_muser;
    logic           t_mlast, t_mvalid, t_mready, t_busy;
    logic [1:0]     t_grant;

    int checks = 0;
    int errors = 0;

    axis_pkt_arbiter #(.S_COUNT(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_data(s_data), .s_id(s_id), .s_user(s_user),
        .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_id(m_id), .m_user(m_user),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .grant_idx(grant_idx), .busy(busy)
    );

    axis_pkt_arbiter #(.S_COUNT(M)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .s_data(t_data), .s_id(t_id), .s_user(t_user),
        .s_last(t_last), .s_valid(t_valid), .s_ready(t_ready),
        .m_data(t_mdata), .m_id(t_mid), .m_user(t_muser),
        .m_last(t_mlast), .m_valid(t_mvalid), .m_ready(t_mready),
        .grant_idx(t_grant), .busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [7:0] d, input logic last);
        s_data[p*8 +: 8] = d;
        s_id[p*8 +: 8]   = d ^ 8'h55;
        s_user[p*8 +: 8] = d ^ 8'hAA;
        s_last[p]        = last;
        s_valid[p]       = 1'b1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        s_valid  = '0; s_last = '0; s_data = '0; s_id = '0; s_user = '0;
        t_valid  = '0; t_last = '0; t_data = '0; t_id = '0; t_user = '0;
        m_ready  = 1'b1;
        t_mready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst m_valid", 32'(m_valid), 0);
        chk("rst s_ready", 32'(s_ready), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst grant", 32'(grant_idx), 0);
        chk("rst payload", {m_data, m_id, m_user, 7'd0, m_last}, 0);
        reset_n = 1'b1;
        step();
    endtask

    // Packet-level model: round-robin pick by modular search from a pointer.
    function automatic int pick_rr(input int ptr0, input logic [N-1:0] v);
        for (int k = 0; k < int'(N); k++) begin
            if (v[(ptr0 + k) % N]) return (ptr0 + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] pay(input int p, input int unsigned pn, input int unsigned b);
        return 8'(p * 64 + int'(pn % 8) * 8 + int'(b));
    endfunction

    typedef struct {
        logic [N-1:0] valid;
        int           gnt;
    } vec_t;

    vec_t tbl[10];

    int unsigned beat[N], len[N], pno[N];
    logic [N-1:0] hs;
    int ptr, cur, exp_g;
    bit arb_pend, bubble, is_last;

    task automatic apply_src(input int p);
        s_data[p*8 +: 8] = pay(p, pno[p], beat[p]);
        s_id[p*8 +: 8]   = 8'(pno[p]);
        s_user[p*8 +: 8] = 8'(p * 16 + int'(beat[p]));
        s_last[p]        = (beat[p] == len[p] - 1);
    endtask

    initial begin
        // Single-beat arbitration vectors, applied back to back from pointer 0.
        tbl[0] = '{4'b0001, 0};
        tbl[1] = '{4'b0001, 0};
        tbl[2] = '{4'b1111, 1};
        tbl[3] = '{4'b1011, 3};
        tbl[4] = '{4'b1010, 1};
        tbl[5] = '{4'b0100, 2};
        tbl[6] = '{4'b0011, 0};
        tbl[7] = '{4'b1000, 3};
        tbl[8] = '{4'b0010, 1};
        tbl[9] = '{4'b0010, 1};

        do_reset();

        // 3-beat packet on port 2, then confirm the pointer moved to 3.
        put(2, 8'h20, 1'b0);
        @(negedge clk); chk("t1 idle busy", 32'(busy), 0); chk("t1 idle m_valid", 32'(m_valid), 0);
        step();
        @(negedge clk); chk("t1 grant", 32'(grant_idx), 2); chk("t1 busy", 32'(busy), 1);
        chk("t1 beat0", {m_data, m_id, m_user, 7'd0, m_last}, {8'h20, 8'h75, 8'h8A, 8'h00});
        step(); put(2, 8'h21, 1'b0);
        @(negedge clk); chk("t1 beat1", {m_data, 7'd0, m_last}, {8'h21, 8'h00});
        step(); put(2, 8'h22, 1'b1);
        @(negedge clk); chk("t1 beat2", {m_data, 7'd0, m_last}, {8'h22, 8'h01});
        chk("t1 s_ready", 32'(s_ready), 32'b0100);
        step(); s_valid = '0;
        @(negedge clk); chk("t1 bubble busy", 32'(busy), 0); chk("t1 bubble m_valid", 32'(m_valid), 0);
        put(0, 8'h00, 1'b1); put(3, 8'h30, 1'b1);
        step();
        @(negedge clk); chk("t1 rr_ptr3 grant", 32'(grant_idx), 3);
        step(); s_valid = '0;

        // Arbitration table.
        for (int k = 0; k < 10; k++) begin
            for (int p = 0; p < int'(N); p++) begin
                s_data[p*8 +: 8] = 8'(8'hA0 + p);
                s_last[p]        = 1'b1;
            end
            s_valid = tbl[k].valid;
            @(negedge clk); chk("tbl idle busy", 32'(busy), 0);
            step();
            @(negedge clk);
            chk("tbl grant", 32'(grant_idx), 32'(tbl[k].gnt));
            chk("tbl m_valid", 32'(m_valid), 1);
            chk("tbl m_data", 32'(m_data), 32'(8'hA0 + tbl[k].gnt));
            chk("tbl s_ready", 32'(s_ready), 32'(1) << tbl[k].gnt);
            step(); s_valid = '0;
        end
        // Pointer is now 2; bring it to 0 with a port-3 packet.
        put(3, 8'h31, 1'b1);
        step(); step(); s_valid = '0;

        // Port 0 stalled mid-packet while port 3 requests.
        put(0, 8'h40, 1'b0);
        step();
        @(negedge clk); chk("t4 grant0", 32'(grant_idx), 0);
        step(); put(0, 8'h41, 1'b1); put(3, 8'h3F, 1'b1); m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4 stall hold", {m_data, 6'd0, m_valid, m_last}, {8'h41, 8'h03});
            chk("t4 stall s_ready", 32'(s_ready), 0);
            chk("t4 stall grant", 32'(grant_idx), 0);
            step();
        end
        m_ready = 1'b1;
        @(negedge clk); chk("t4 release s_ready", 32'(s_ready), 32'b0001);
        step(); s_valid[0] = 1'b0;
        @(negedge clk); chk("t4 bubble", 32'(m_valid), 0);
        step();
        @(negedge clk); chk("t4 port3 grant", 32'(grant_idx), 3); chk("t4 port3 data", 32'(m_data), 32'h3F);
        step(); s_valid = '0;

        // Move pointer to 2, then reset during beat 2 of a port-3 packet.
        put(1, 8'h11, 1'b1);
        step(); step(); s_valid = '0;
        put(3, 8'h50, 1'b0);
        step(); step(); put(3, 8'h51, 1'b0);
        step(); put(3, 8'h52, 1'b0);
        @(negedge clk); chk("t6 beat2", 32'(m_data), 32'h52);
        #2 reset_n = 1'b0;
        #1;
        chk("t6 async m_valid", 32'(m_valid), 0);
        chk("t6 async s_ready", 32'(s_ready), 0);
        chk("t6 async grant", 32'(grant_idx), 0);
        chk("t6 async busy", 32'(busy), 0);
        s_valid = '0;
        @(negedge clk); reset_n = 1'b1;
        step();
        put(1, 8'h12, 1'b1); put(3, 8'h53, 1'b1);
        step();
        @(negedge clk); chk("t6 rr from 0", 32'(grant_idx), 1);
        step(); s_valid = '0;

        // Three-port instance: pointer wrap from 2 to 0.
        for (int p = 0; p < int'(M); p++) t_data[p*8 +: 8] = 8'(8'hC0 + p);
        t_last = '1; t_valid = 3'b010;
        step();
        @(negedge clk); chk("t3 first grant", 32'(t_grant), 1);
        step(); t_valid = 3'b110;
        @(negedge clk); chk("t3 idle", 32'(t_busy), 0);
        step();
        @(negedge clk); chk("t3 grant2", 32'(t_grant), 2); chk("t3 data2", 32'(t_mdata), 32'hC2);
        step(); t_valid = 3'b010;
        step();
        @(negedge clk); chk("t3 wrap grant1", 32'(t_grant), 1); chk("t3 data1", 32'(t_mdata), 32'hC1);
        step(); t_valid = '0;

        // Randomized run against the packet-level model.
        do_reset();
        ptr = 0; cur = 0; arb_pend = 0; bubble = 0;
        for (int p = 0; p < int'(N); p++) begin
            beat[p] = 0; pno[p] = 0; len[p] = 1 + $urandom % 4;
            apply_src(p);
        end
        s_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (arb_pend) begin
                chk("rnd arb busy", 32'(busy), 1);
                chk("rnd grant", 32'(grant_idx), 32'(exp_g));
                cur = exp_g;
                arb_pend = 0;
            end
            if (bubble) begin
                chk("rnd bubble", 32'(busy), 0);
                bubble = 0;
            end
            if (!busy) begin
                chk("rnd idle m_valid", 32'(m_valid), 0);
                if (s_valid != '0) begin
                    arb_pend = 1;
                    exp_g = pick_rr(ptr, s_valid);
                end
            end else begin
                chk("rnd s_ready", 32'(s_ready), m_ready ? (32'(1) << cur) : 32'(0));
                chk("rnd m_valid", 32'(m_valid), 32'(s_valid[cur]));
                if (m_valid && m_ready) begin
                    is_last = (beat[cur] == len[cur] - 1);
                    chk("rnd beat", {m_data, m_id, m_user, 7'd0, m_last},
                        {pay(cur, pno[cur], beat[cur]), 8'(pno[cur]),
                         8'(cur * 16 + int'(beat[cur])), 7'd0, is_last});
                    if (is_last) begin
                        ptr = (cur + 1) % N;
                        bubble = 1;
                    end
                end
            end
            hs = s_valid & s_ready;
            step();
            for (int p = 0; p < int'(N); p++) begin
                if (hs[p]) begin
                    if (beat[p] == len[p] - 1) begin
                        pno[p]++;
                        beat[p] = 0;
                        len[p] = 1 + $urandom % 4;
                    end else begin
                        beat[p]++;
                    end
                    s_valid[p] = ($urandom % 4 != 0);
                end else if (!s_valid[p]) begin
                    s_valid[p] = ($urandom % 3 == 0);
                end
                apply_src(p);
            end
            m_ready = ($urandom % 4 != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- S_COUNT-input, 1-output AXI-Stream packet arbiter with round-robin fairness.
- Sits directly upstream of the switch's axis_register output stage and feeds its slave port.
- Once a source is granted, the grant is held for that whole packet (through the TLAST beat); interleaving of packets from different sources is impossible.

Parameters:
- S_COUNT, 4, number of slave (input) ports; legal range 2..16, need not be a power of 2.
- T_DATA_WIDTH, 8, TDATA width per port.
- T_ID_WIDTH, 8, TID width per port.
- T_USER_WIDTH, 8, TUSER width per port.
- GW (localparam), $clog2(S_COUNT), width of the grant index.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_data  in  S_COUNT*T_DATA_WIDTH  packed TDATA; port i occupies bits [i*T_DATA_WIDTH +: T_DATA_WIDTH].
- s_id  in  S_COUNT*T_ID_WIDTH  packed TID, same layout.
- s_user  in  S_COUNT*T_USER_WIDTH  packed TUSER, same layout.
- s_last  in  S_COUNT  TLAST per port.
- s_valid  in  S_COUNT  TVALID per port.
- s_ready  out  S_COUNT  TREADY per port.
- m_data  out  T_DATA_WIDTH  output TDATA.
- m_id  out  T_ID_WIDTH  output TID.
- m_user  out  T_USER_WIDTH  output TUSER.
- m_last  out  1  output TLAST.
- m_valid  out  1  output TVALID.
- m_ready  in  1  output TREADY.
- grant_idx  out  GW  index of the currently or last granted port.
- busy  out  1  high while in BUSY.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - Outputs during and after reset: m_valid=0, s_ready=0, busy=0, m_data/m_id/m_user/m_last=0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - s_ready=0 on all ports; m_valid=0; m_* payload driven to 0.
  - If any s_valid is high: grant_idx <= first index j with s_valid[j]=1, searching rr_ptr, rr_ptr+1, ..., S_COUNT-1, 0, ..., rr_ptr-1. Next state is BUSY.
  - If no s_valid is high: remain in IDLE, no state change.
- BUSY:
  - m_valid=s_valid[g], m_data/m_id/m_user/m_last = port g fields, where g = grant_idx. These paths are purely combinational.
  - s_ready[g]=m_ready; s_ready[k]=0 for every k != g.
  - grant_idx is frozen while in BUSY.
- Packet end: on a beat with m_valid & m_ready & m_last:
  - rr_ptr <= (g==S_COUNT-1) ? 0 : g+1;
  - next state is IDLE.
- Latency:
  - Arbitration costs exactly one cycle; there is no datapath register.
  - First beat of a packet can transfer at the earliest one cycle after s_valid rises.
  - Exactly one idle bubble (m_valid=0) follows every TLAST beat.
- Single-beat packets (s_last=1 on the first beat) are legal: IDLE -> BUSY -> IDLE in 2 cycles.
- Non-granted sources are held off with s_ready=0; their valid/payload must remain stable per AXI-Stream rules. The arbiter does not buffer them.
- Output stability:
  - With a stable grant and compliant sources, m_valid & ~m_ready implies m_valid and the m_* payload are unchanged next cycle.
  - m_valid never drops without a handshake while in BUSY.
- Granted source drops s_valid mid-packet (gap): m_valid follows it low, grant is held, state stays BUSY. No timeout.
- New s_valid assertions on other ports during BUSY do not affect the current grant; they are considered in the next IDLE cycle.
- Wrap-around: rr_ptr wraps from S_COUNT-1 to 0, and the search wraps modulo S_COUNT. With non-power-of-2 S_COUNT, indices >= S_COUNT are never produced.
- Reset asserted mid-packet: immediate return to reset state. The remainder of the packet is not forwarded; this is an upstream concern.
- m_valid is never X after reset; no combinational path exists from m_ready to m_valid.

Test Plan:
1. Reset, then s_valid=4'b0100 with a 3-beat packet on port 2, m_ready=1:
   - grant_idx=2, busy=1 on cycle+1;
   - 3 beats emerge on consecutive cycles with m_last on the third;
   - busy=0 next cycle; rr_ptr=3.
2. All 4 ports continuously valid with 2-beat packets, m_ready=1:
   - grant order 0,1,2,3,0,1, one bubble between packets;
   - no beat interleaving; 6 packets in 18 cycles.
3. S_COUNT=3, ports 1 and 2 requesting, rr_ptr=2:
   - port 2 granted first, then rr_ptr wraps to 0, then port 1 granted.
4. Granted port 0 mid-packet, m_ready=0 for 5 cycles while port 3 raises s_valid:
   - m_* stable, s_ready=0 on all ports, grant stays 0;
   - port 3 served after port 0's TLAST.
5. Single-beat packets (last=1) on port 1 back-to-back:
   - each accepted 2 cycles apart; rr_ptr=2 after each; port 1 re-granted when it is the sole requester.
6. reset_n pulsed low during beat 2 of a 4-beat packet on port 3:
   - m_valid=0, s_ready=0, grant_idx=0 asynchronously;
   - after release, the next request is arbitrated from rr_ptr=0.
